// File: rtl/edward_cmul_pipe.sv
// Pipelined multiply of an unsigned operand by one of two signed-digit constants.
// Shift-add only: S1 group sums, S2 pos/neg reductions, S3 final subtraction.
module edward_cmul_pipe #(
    parameter int unsigned          R_WIDTH   = 256,
    parameter int unsigned          K_WIDTH   = 256,
    parameter logic [K_WIDTH-1:0]   POS_MASK0 = '0,
    parameter logic [K_WIDTH-1:0]   NEG_MASK0 = '0,
    parameter logic [K_WIDTH-1:0]   POS_MASK1 = '0,
    parameter logic [K_WIDTH-1:0]   NEG_MASK1 = '0,
    parameter int unsigned          TAG_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vld,
    output logic                         o_rdy,
    input  logic                         i_mode,
    input  logic [R_WIDTH-1:0]           i_s,
    input  logic [TAG_WIDTH-1:0]         i_tag,
    input  logic                         i_flush,
    output logic                         o_vld,
    input  logic                         i_rdy,
    output logic [R_WIDTH+K_WIDTH-1:0]   o_t,
    output logic [TAG_WIDTH-1:0]         o_tag,
    output logic                         o_busy
);

    localparam int unsigned OW = R_WIDTH + K_WIDTH;
    localparam int unsigned NG = (K_WIDTH + 3) / 4;
    localparam int unsigned KP = NG * 4;

    // A digit cannot be both +1 and -1.
    if ((POS_MASK0 & NEG_MASK0) != '0) begin : g_bad_mask0
        $error("edward_cmul_pipe: POS_MASK0 and NEG_MASK0 overlap");
    end
    if ((POS_MASK1 & NEG_MASK1) != '0) begin : g_bad_mask1
        $error("edward_cmul_pipe: POS_MASK1 and NEG_MASK1 overlap");
    end

    logic                 s1_vld;
    logic                 s2_vld;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 accept;

    logic [KP-1:0]        pmask;
    logic [KP-1:0]        nmask;
    logic [OW-1:0]        s_ext;
    logic [OW-1:0]        pos_grp_c [NG];
    logic [OW-1:0]        neg_grp_c [NG];
    logic [OW-1:0]        s1_pos    [NG];
    logic [OW-1:0]        s1_neg    [NG];
    logic [TAG_WIDTH-1:0] s1_tag;

    logic [OW-1:0]        pos_sum_c;
    logic [OW-1:0]        neg_sum_c;
    logic [OW-1:0]        s2_pos;
    logic [OW-1:0]        s2_neg;
    logic [TAG_WIDTH-1:0] s2_tag;

    // Handshake: a stage moves when the one after it is empty or moving; flush freezes all.
    always_comb begin
        s2_adv = s2_vld && (!o_vld || i_rdy) && !i_flush;
        s1_adv = s1_vld && (!s2_vld || s2_adv) && !i_flush;
        o_rdy  = !i_rst && !i_flush && (!s1_vld || s1_adv);
        accept = i_vld && o_rdy;
    end

    assign o_busy = s1_vld | s2_vld | o_vld;

    // S1: mode-selected digits, summed in groups of four shifted copies.
    always_comb begin
        pmask = i_mode ? KP'(POS_MASK1) : KP'(POS_MASK0);
        nmask = i_mode ? KP'(NEG_MASK1) : KP'(NEG_MASK0);
        s_ext = OW'(i_s);
        for (int unsigned g = 0; g < NG; g++) begin
            pos_grp_c[g] = '0;
            neg_grp_c[g] = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                if (pmask[4*g+j]) pos_grp_c[g] = pos_grp_c[g] + (s_ext << (4*g+j));
                if (nmask[4*g+j]) neg_grp_c[g] = neg_grp_c[g] + (s_ext << (4*g+j));
            end
        end
    end

    // S2: independent reductions of the positive and negative group sums.
    always_comb begin
        pos_sum_c = '0;
        neg_sum_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            pos_sum_c = pos_sum_c + s1_pos[g];
            neg_sum_c = neg_sum_c + s1_neg[g];
        end
    end

    // Valid bits and the output register; flush outranks accept and consume.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            o_vld  <= 1'b0;
            o_t    <= '0;
            o_tag  <= '0;
        end else if (i_flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            o_vld  <= 1'b0;
        end else begin
            if (accept)      s1_vld <= 1'b1;
            else if (s1_adv) s1_vld <= 1'b0;

            if (s1_adv)      s2_vld <= 1'b1;
            else if (s2_adv) s2_vld <= 1'b0;

            if (s2_adv) begin
                o_vld <= 1'b1;
                o_t   <= s2_pos - s2_neg;
                o_tag <= s2_tag;
            end else if (i_rdy) begin
                o_vld <= 1'b0;
            end
        end
    end

    // Internal data registers only load on advance, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_pos <= pos_grp_c;
            s1_neg <= neg_grp_c;
            s1_tag <= i_tag;
        end
        if (s1_adv) begin
            s2_pos <= pos_sum_c;
            s2_neg <= neg_sum_c;
            s2_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_edward_cmul_pipe.sv
// Directed and random checks of edward_cmul_pipe against a queue-based arithmetic model.
// A second instance with a negative mode-0 constant shares all inputs.
module tb_edward_cmul_pipe;

    localparam logic [15:0] P0  = 16'h0011;
    localparam logic [15:0] N0  = 16'h0002;
    localparam logic [15:0] P1  = 16'h0100;
    localparam logic [15:0] N1  = 16'h0001;
    localparam logic [15:0] P0N = 16'h0001;
    localparam logic [15:0] N0N = 16'h0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] s = '0;
    logic [7:0]  tag = '0;
    logic        flush = 1'b0;
    logic        rdy = 1'b0;

    logic        o_rdy, o_vld, o_busy;
    logic [31:0] o_t;
    logic [7:0]  o_tag;
    logic        n_rdy, n_vld, n_busy;
    logic [31:0] n_t;
    logic [7:0]  n_tag;

    always #5 clk = ~clk;

    edward_cmul_pipe #(
        .R_WIDTH(16), .K_WIDTH(16),
        .POS_MASK0(P0), .NEG_MASK0(N0), .POS_MASK1(P1), .NEG_MASK1(N1),
        .TAG_WIDTH(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(o_rdy), .i_mode(mode),
        .i_s(s), .i_tag(tag), .i_flush(flush), .o_vld(o_vld), .i_rdy(rdy),
        .o_t(o_t), .o_tag(o_tag), .o_busy(o_busy)
    );

    edward_cmul_pipe #(
        .R_WIDTH(16), .K_WIDTH(16),
        .POS_MASK0(P0N), .NEG_MASK0(N0N), .POS_MASK1(P1), .NEG_MASK1(N1),
        .TAG_WIDTH(8)
    ) dut_n (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(n_rdy), .i_mode(mode),
        .i_s(s), .i_tag(tag), .i_flush(flush), .o_vld(n_vld), .i_rdy(rdy),
        .o_t(n_t), .o_tag(n_tag), .o_busy(n_busy)
    );

    typedef struct {
        logic [31:0] t;
        logic [31:0] tn;
        logic [7:0]  tag;
        int          cyc;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_acc = 0;
    int   n_cons = 0;

    logic        last_vld, last_rdy, last_busy;
    logic [31:0] last_t, last_tn;
    logic [7:0]  last_tag;

    function automatic longint kval(input logic [15:0] p, input logic [15:0] n);
        return longint'(p) - longint'(n);
    endfunction

    function automatic logic [31:0] model(input logic [15:0] sv, input longint k);
        return 32'(longint'(sv) * k);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model at the edge.
    task automatic step(input logic v, input logic m, input logic [15:0] sv,
                        input logic [7:0] tg, input logic r, input logic fl);
        logic exp_vld, acc, cons;
        ent_t e;
        @(negedge clk);
        vld = v; mode = m; s = sv; tag = tg; rdy = r; flush = fl;
        #1;
        exp_vld = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
        chk("o_vld", 64'(o_vld), 64'(exp_vld));
        chk("n_vld", 64'(n_vld), 64'(exp_vld));
        chk("o_busy", 64'(o_busy), 64'(q.size() > 0));
        chk("o_rdy", 64'(o_rdy), 64'(!fl && (q.size() < 3 || r)));
        if (o_vld && q.size() > 0) begin
            chk("o_t", 64'(o_t), 64'(q[0].t));
            chk("o_tag", 64'(o_tag), 64'(q[0].tag));
            chk("n_t", 64'(n_t), 64'(q[0].tn));
        end
        last_vld = o_vld; last_rdy = o_rdy; last_busy = o_busy;
        last_t = o_t; last_tn = n_t; last_tag = o_tag;
        acc  = v && o_rdy;
        cons = o_vld && r;
        @(posedge clk);
        cyc++;
        if (fl) begin
            q.delete();
        end else begin
            if (cons && q.size() > 0) begin
                void'(q.pop_front());
                n_cons++;
            end
            if (acc) begin
                e.t   = model(sv, m ? kval(P1, N1) : kval(P0, N0));
                e.tn  = model(sv, m ? kval(P1, N1) : kval(P0N, N0N));
                e.tag = tg;
                e.cyc = cyc;
                q.push_back(e);
                n_acc++;
            end
        end
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 8'h0, r, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_vld"}, 64'(o_vld), 64'(0));
        chk({name, "_busy"}, 64'(o_busy), 64'(0));
        chk({name, "_rdy"}, 64'(o_rdy), 64'(0));
        chk({name, "_t"}, 64'(o_t), 64'(0));
        chk({name, "_tag"}, 64'(o_tag), 64'(0));
        chk({name, "_nt"}, 64'(n_t), 64'(0));
    endtask

    initial begin
        // Reset state
        #2;
        chk_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single mode-0 operand, three-cycle latency
        step(1'b1, 1'b0, 16'd3, 8'h5A, 1'b1, 1'b0);
        idle(1'b1, 2);
        chk("lat_early_vld", 64'(last_vld), 64'(0));
        idle(1'b1, 1);
        chk("m0_vld", 64'(last_vld), 64'(1));
        chk("m0_t", 64'(last_t), 64'(45));
        chk("m0_tag", 64'(last_tag), 64'(8'h5A));
        chk("m0_neg_t", 64'(last_tn), 64'(32'hFFFF_FFF7));
        idle(1'b1, 2);

        // Back-to-back operands with alternating modes
        step(1'b1, 1'b1, 16'd2, 8'h11, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 8'h22, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("b2b_first_pending", 64'(last_vld), 64'(0));
        idle(1'b1, 1);
        chk("b2b_t0", 64'(last_t), 64'(510));
        idle(1'b1, 1);
        chk("b2b_vld1", 64'(last_vld), 64'(1));
        chk("b2b_t1", 64'(last_t), 64'(32'h000E_FFF1));
        idle(1'b1, 2);

        // Negative constant wraps modulo 2^32
        step(1'b1, 1'b0, 16'd1, 8'h33, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("neg_vld", 64'(last_vld), 64'(1));
        chk("neg_t", 64'(last_tn), 64'(32'hFFFF_FFFD));
        idle(1'b1, 2);

        // Stall: only three operands fit, then drain in order
        n_acc = 0;
        n_cons = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 16'(100 + i), 8'(i), 1'b0, 1'b0);
        chk("stall_rdy4", 64'(last_rdy), 64'(0));
        chk("stall_acc", 64'(n_acc), 64'(3));
        idle(1'b1, 6);
        chk("stall_drain", 64'(n_cons), 64'(3));
        chk("stall_empty", 64'(last_busy), 64'(0));

        // Flush with two in flight and a pending operand
        step(1'b1, 1'b0, 16'd7, 8'h44, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'd9, 8'h45, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'd11, 8'h46, 1'b1, 1'b1);
        chk("flush_rdy", 64'(last_rdy), 64'(0));
        idle(1'b1, 1);
        chk("flush_vld", 64'(last_vld), 64'(0));
        chk("flush_busy", 64'(last_busy), 64'(0));
        idle(1'b1, 4);

        // Reset mid-operation with three in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'(i), 16'(500 + i), 8'(8'h80 + i), 1'b0, 1'b0);
        @(negedge clk);
        vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        idle(1'b1, 1);
        chk("rst_rel_rdy", 64'(last_rdy), 64'(1));
        idle(1'b1, 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(1'b1, 6);
        chk("final_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edward_cmul_pipe.md
EDWARD_CMUL_PIPE -- requirements
Module: edward_cmul_pipe

Interface
REQ-001 Parameter R_WIDTH, 256, operand width in bits.
REQ-002 Parameter K_WIDTH, 256, signed-digit constant span in bits; output width OW = R_WIDTH + K_WIDTH.
REQ-003 Parameters POS_MASK0 and NEG_MASK0, K_WIDTH bits each, default 0: mode-0 constant K0 = POS_MASK0 - NEG_MASK0.
REQ-004 Parameters POS_MASK1 and NEG_MASK1, K_WIDTH bits each, default 0: mode-1 constant K1 = POS_MASK1 - NEG_MASK1.
REQ-005 Parameter TAG_WIDTH, 8, sideband tag width.
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst  in  1  asynchronous, active-high reset.
REQ-008 i_vld  in  1  input operand valid.
REQ-009 o_rdy  out  1  block accepts an operand this cycle.
REQ-010 i_mode  in  1  constant select: 0 selects K0, 1 selects K1.
REQ-011 i_s  in  R_WIDTH  unsigned operand.
REQ-012 i_tag  in  TAG_WIDTH  sideband tag, returned with the result.
REQ-013 i_flush  in  1  synchronous pipeline flush.
REQ-014 o_vld  out  1  result valid.
REQ-015 i_rdy  in  1  downstream accepts the result.
REQ-016 o_t  out  OW  product.
REQ-017 o_tag  out  TAG_WIDTH  tag of the result on o_t.
REQ-018 o_busy  out  1  at least one pipeline stage holds a valid entry.

Function
REQ-019 An operand is accepted when i_vld && o_rdy is high at a rising clock edge; a result is consumed when o_vld && i_rdy is high.
REQ-020 o_t = (i_s * Kmode) mod 2^OW, in two's complement; a negative K wraps, so i_s=1 with K=-3 gives 2^OW-3.
REQ-021 Each set bit of a POS mask adds i_s shifted left by that bit position; each set bit of a NEG mask subtracts it; no hardware multiplier.
REQ-022 A set bit in both POS_MASKn and NEG_MASKn is a configuration error, reported by an elaboration-time check.
REQ-023 The pipeline has three stages:
  - S1: per-mode grouped partial sums of at most 4 shifted terms.
  - S2: separate positive and negative reductions.
  - S3: final subtraction into the output register.
REQ-024 With i_rdy held high, latency is 3 cycles from the accept edge to o_vld high with the result, and throughput is 1 result per cycle.
REQ-025 i_mode and i_tag are captured at accept and travel with the operand; consecutive operands can use different modes with no bubble.
REQ-026 Each stage advances when its successor is empty or advancing this cycle; bubbles collapse under stall.
REQ-027 o_rdy = !S1_valid || S1_advancing; o_rdy does not depend combinationally on i_vld.
REQ-028 While o_vld is high and i_rdy is low, o_t, o_tag and o_vld stay constant.
REQ-029 Up to 3 operands can be in flight; with i_rdy low, the 4th operand is not accepted (o_rdy low).
REQ-030 i_flush high at a clock edge clears all stage valids and o_vld; o_rdy is low in that cycle and no operand is accepted; flush has priority over simultaneous accept and consume.
REQ-031 Data registers load only on stage advance; invalid stages never drive o_t.
REQ-032 o_busy = OR of the S1, S2 and S3 valid bits.

Reset
REQ-033 While i_rst is high, all valid bits, o_vld, o_busy, o_t and o_tag are 0, asynchronously.
REQ-034 o_rdy is 0 while i_rst is high and 1 in the first cycle after deassertion.
REQ-035 Reset asserted mid-operation discards all in-flight entries; no stale result appears after release.

Verification (test parameters: R_WIDTH=16, K_WIDTH=16, POS_MASK0=0x0011, NEG_MASK0=0x0002 so K0=15; POS_MASK1=0x0100, NEG_MASK1=0x0001 so K1=255)
REQ-036 Mode-0 single operand: i_s=3, tag=0x5A, i_rdy=1 -> 3 cycles later o_vld=1, o_t=45, o_tag=0x5A.
REQ-037 Back-to-back modes: i_s=2 mode 1, then i_s=0xFFFF mode 0 -> o_t=510, then 0xEFFF1, on consecutive cycles.
REQ-038 Stall: i_rdy=0, drive 4 operands -> 3 accepted and o_rdy=0 on the 4th; i_rdy=1 -> results drain in order with no loss or duplication.
REQ-039 Negative constant (POS_MASK0=0x0001, NEG_MASK0=0x0004, K0=-3): i_s=1 -> o_t=0xFFFFFFFD.
REQ-040 Flush with 2 entries in flight and i_vld=1 -> no operand accepted, o_vld=0 and o_busy=0 next cycle, and nothing emerges later.
REQ-041 Reset pulse while 3 entries are in flight -> all outputs 0 immediately, o_rdy=1 after release, and no result emerges.
